// File: rtl/serial_word_deserializer_if.sv
// -----------------------------------------------------------------------------
// serial_word_deserializer_if
// Purpose : bundles the serial-input and parallel-output handshakes of the
//           serial word deserializer, plus its control and status signals.
// Signals : msb_first, frame_sync    control (master -> slave)
//           s_din, s_valid, s_ready  serial bit handshake
//           p_dout, p_valid, p_ready assembled-word handshake
//           bit_cnt                  number of bits held in the partial word
// Modports: slave  - the deserializer itself
//           master - the block driving bits in and taking words out
// -----------------------------------------------------------------------------
interface serial_word_deserializer_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH);

  logic             msb_first;
  logic             frame_sync;
  logic             s_din;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] p_dout;
  logic             p_valid;
  logic             p_ready;
  logic [CW-1:0]    bit_cnt;

  modport slave (
    input  msb_first, frame_sync, s_din, s_valid, p_ready,
    output s_ready, p_dout, p_valid, bit_cnt
  );

  modport master (
    output msb_first, frame_sync, s_din, s_valid, p_ready,
    input  s_ready, p_dout, p_valid, bit_cnt
  );
endinterface

// File: rtl/serial_word_deserializer.sv
// -----------------------------------------------------------------------------
// serial_word_deserializer
// Purpose : assembles WIDTH-bit words from a serial bit stream (one bit per
//           accepted cycle), MSB-first or LSB-first, and presents each word on
//           a registered parallel output with valid/ready backpressure.
// Ports   : clk    - clock, rising edge
//           rst_n  - synchronous active-low reset
//           bus    - serial_word_deserializer_if.slave (see interface header)
// -----------------------------------------------------------------------------
module serial_word_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  serial_word_deserializer_if.slave    bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             order_q, order_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             pvalid_q, pvalid_d;

  logic [WIDTH-1:0] eff_sr;
  logic [CW-1:0]    eff_cnt;
  logic             order_use;
  logic [WIDTH-1:0] shifted;
  logic             s_ready;
  logic             accept;
  logic             first_bit;
  logic             last_bit;

  // The final bit of a word may only enter when the output register can take
  // it. frame_sync restarts the word, so the pending bit is never the last one.
  assign s_ready = rst_n && (bus.frame_sync || (cnt_q != LAST_IDX) ||
                             !pvalid_q || bus.p_ready);
  assign accept  = bus.s_valid && s_ready;

  always_comb begin
    // frame_sync makes the partial word look empty for this cycle.
    eff_cnt   = bus.frame_sync ? '0 : cnt_q;
    eff_sr    = bus.frame_sync ? '0 : sr_q;
    first_bit = (eff_cnt == '0);
    last_bit  = (eff_cnt == LAST_IDX);
    // The first bit of a word uses the live order input; later bits use the
    // order captured with that first bit.
    order_use = first_bit ? bus.msb_first : order_q;
    shifted   = order_use ? {eff_sr[WIDTH-2:0], bus.s_din}
                          : {bus.s_din, eff_sr[WIDTH-1:1]};

    sr_d     = eff_sr;
    cnt_d    = eff_cnt;
    order_d  = order_q;
    dout_d   = dout_q;
    pvalid_d = pvalid_q;

    if (accept) begin
      if (first_bit) begin
        order_d = bus.msb_first;
      end
      if (last_bit) begin
        sr_d  = '0;
        cnt_d = '0;
      end else begin
        sr_d  = shifted;
        cnt_d = eff_cnt + CW'(1);
      end
    end

    // Consume first, then let a completing word override so back-to-back
    // words keep p_valid high with no bubble.
    if (pvalid_q && bus.p_ready) begin
      pvalid_d = 1'b0;
    end
    if (accept && last_bit) begin
      dout_d   = shifted;
      pvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q     <= '0;
      cnt_q    <= '0;
      order_q  <= 1'b1;
      dout_q   <= '0;
      pvalid_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      order_q  <= order_d;
      dout_q   <= dout_d;
      pvalid_q <= pvalid_d;
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.p_dout  = dout_q;
  assign bus.p_valid = pvalid_q;
  assign bus.bit_cnt = cnt_q;
endmodule

// File: tb/tb_serial_word_deserializer.sv
// -----------------------------------------------------------------------------
// tb_serial_word_deserializer
// Directed stimulus for the serial word deserializer. Expected words are pushed
// into a queue as they are sent; a monitor pops one on every consumed output.
// -----------------------------------------------------------------------------
module tb_serial_word_deserializer;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;

  serial_word_deserializer_if #(.WIDTH(WIDTH)) bus ();

  serial_word_deserializer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: every consumed word is checked against the queue.
  always @(negedge clk) begin
    if (rst_n && bus.p_valid && bus.p_ready) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL word_unexpected: got 0x%0h, expected no word", bus.p_dout);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (bus.p_dout == e) begin
          pass_cnt++;
          $display("word 0x%02h consumed (expected 0x%02h)", bus.p_dout, e);
        end else begin
          $display("FAIL word: got 0x%0h, expected 0x%0h", bus.p_dout, e);
        end
      end
    end
  end

  // Present one bit and hold it until accepted (bounded wait).
  task automatic send_bit(input logic b);
    int guard;
    guard = 0;
    bus.s_din   = b;
    bus.s_valid = 1'b1;
    @(negedge clk);
    while (!bus.s_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.s_ready) chk("send_bit_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  // Send bits of w, first-sent bit is w[WIDTH-1] (used for MSB-first words).
  task automatic send_word_msb(input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  int pv_count;

  initial begin
    logic [WIDTH-1:0] bits;
    logic [WIDTH-1:0] words [4];

    rst_n          = 1'b0;
    bus.msb_first  = 1'b1;
    bus.frame_sync = 1'b0;
    bus.s_din      = 1'b0;
    bus.s_valid    = 1'b1;
    bus.p_ready    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_p_valid", int'(bus.p_valid), 0);
    chk("reset_p_dout", int'(bus.p_dout), 0);
    chk("reset_bit_cnt", int'(bus.bit_cnt), 0);
    chk("reset_s_ready", int'(bus.s_ready), 0);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: MSB-first 1,1,0,1,0,0,0,0 -> D0, one-cycle p_valid pulse
    exp_q.push_back(8'hD0);
    send_word_msb(8'hD0);
    @(negedge clk);
    chk("t1_p_valid", int'(bus.p_valid), 1);
    chk("t1_p_dout", int'(bus.p_dout), 'hD0);
    chk("t1_bit_cnt", int'(bus.bit_cnt), 0);
    @(negedge clk);
    chk("t1_p_valid_drop", int'(bus.p_valid), 0);
    @(posedge clk);
    #1;

    // 2: same bits LSB-first -> 0B; second word toggles msb_first after bit 3
    bus.msb_first = 1'b0;
    bits = 8'hD0;
    exp_q.push_back(8'h0B);
    for (int i = WIDTH - 1; i >= 0; i--) send_bit(bits[i]);
    @(negedge clk);
    chk("t2_p_dout", int'(bus.p_dout), 'h0B);
    @(posedge clk);
    #1;
    exp_q.push_back(8'h0B);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i == WIDTH - 4) bus.msb_first = 1'b1;
      send_bit(bits[i]);
    end
    @(negedge clk);
    chk("t2_toggle_p_dout", int'(bus.p_dout), 'h0B);
    @(posedge clk);
    #1;

    // 3: backpressure on the final bit only
    bus.msb_first = 1'b1;
    bus.p_ready   = 1'b0;
    exp_q.push_back(8'hD0);
    exp_q.push_back(8'h3C);
    send_word_msb(8'hD0);
    bits = 8'h3C;
    for (int i = WIDTH - 1; i >= 1; i--) send_bit(bits[i]);
    bus.s_din   = bits[0];
    bus.s_valid = 1'b1;
    @(negedge clk);
    chk("t3_bit_cnt", int'(bus.bit_cnt), 7);
    chk("t3_s_ready_stall", int'(bus.s_ready), 0);
    chk("t3_p_dout_hold", int'(bus.p_dout), 'hD0);
    @(posedge clk);
    #1;
    bus.p_ready = 1'b1;
    @(negedge clk);
    chk("t3_s_ready_release", int'(bus.s_ready), 1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("t3_p_valid_stays", int'(bus.p_valid), 1);
    chk("t3_p_dout_b", int'(bus.p_dout), 'h3C);
    @(posedge clk);
    #1;

    // 4: continuous stream of four words, s_ready never drops
    words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF; words[3] = 8'h5A;
    pv_count = 0;
    for (int w = 0; w < 4; w++) begin
      exp_q.push_back(words[w]);
      bits = words[w];
      for (int i = WIDTH - 1; i >= 0; i--) begin
        bus.s_din   = bits[i];
        bus.s_valid = 1'b1;
        @(negedge clk);
        chk("t4_s_ready", int'(bus.s_ready), 1);
        if (bus.p_valid) pv_count++;
        @(posedge clk);
        #1;
      end
    end
    bus.s_valid = 1'b0;
    @(negedge clk);
    if (bus.p_valid) pv_count++;
    chk("t4_p_valid_pulses", pv_count, 4);
    @(posedge clk);
    #1;

    // 5: frame_sync discards a 3-bit partial word
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    @(negedge clk);
    chk("t5_bit_cnt_partial", int'(bus.bit_cnt), 3);
    @(posedge clk);
    #1;
    bus.frame_sync = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_sync = 1'b0;
    @(negedge clk);
    chk("t5_bit_cnt_sync", int'(bus.bit_cnt), 0);
    @(posedge clk);
    #1;
    exp_q.push_back(8'h5A);
    send_word_msb(8'h5A);
    @(negedge clk);
    chk("t5_p_dout", int'(bus.p_dout), 'h5A);
    @(posedge clk);
    #1;

    // 6: reset mid-word with a word pending discards everything
    bus.p_ready = 1'b0;
    send_word_msb(8'hAA);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_s_ready_in_reset", int'(bus.s_ready), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t6_p_valid", int'(bus.p_valid), 0);
    chk("t6_p_dout", int'(bus.p_dout), 0);
    chk("t6_bit_cnt", int'(bus.bit_cnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.p_ready = 1'b1;
    exp_q.push_back(8'hC3);
    send_word_msb(8'hC3);
    @(negedge clk);
    chk("t6_p_dout_after", int'(bus.p_dout), 'hC3);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/serial_word_deserializer.md
Name: serial_word_deserializer

Overview:
Receive-side counterpart to the universal shift register when that register serialises a word onto its serial outputs. Accepts one serial bit per cycle under a valid/ready handshake and assembles WIDTH-bit words, MSB-first or LSB-first. Presents each completed word on a registered parallel output with valid/ready backpressure. Sits between a serial link or bit-bang front end and word-oriented datapath logic.

Parameters:
WIDTH, 8, word width in bits; legal range WIDTH >= 2.
CW (localparam), $clog2(WIDTH), width of the bit counter.

Ports:
clk  input  1  clock; all logic on rising edge.
rst_n  input  1  synchronous, active-low reset.
msb_first  input  1  order select. 1 = first bit received becomes the MSB (left shift). 0 = first bit received becomes the LSB (right shift).
frame_sync  input  1  restart word alignment; discards any partial word.
s_din  input  1  serial data bit.
s_valid  input  1  s_din is valid this cycle.
s_ready  output  1  block accepts s_din this cycle.
p_dout  output  WIDTH  assembled word (registered).
p_valid  output  1  p_dout holds an unconsumed word.
p_ready  input  1  downstream consumes p_dout this cycle.
bit_cnt  output  CW  number of bits held in the partial word, 0..WIDTH-1.

Behaviour:
- Interface decision: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - Cleared: shift register, bit_cnt, p_dout (0), p_valid (0), latched order bit (1).
  - s_ready is forced 0 while rst_n=0.
  - Reset mid-word or with a word pending discards everything.
- Bit acceptance: a bit is accepted when s_valid && s_ready.
- Order latching: msb_first is latched on the first accepted bit of each word (bit_cnt==0 or frame_sync). Changes to msb_first mid-word have no effect until the next word.
- Shift rules:
  - Order 1: sr <= {sr[WIDTH-2:0], s_din}.
  - Order 0: sr <= {s_din, sr[WIDTH-1:1]}.
  - bit_cnt increments on each accepted bit.
- Completion (accepted bit while bit_cnt==WIDTH-1):
  - Next cycle: p_dout = the shifted value including this bit, p_valid = 1.
  - bit_cnt -> 0 and the shift register clears.
  - Latency: 1 cycle from the final bit accept to p_valid.
- Output handshake:
  - A word is consumed when p_valid && p_ready.
  - p_valid clears the next cycle unless a new word completes in the same cycle. In that case p_dout reloads and p_valid stays 1 (back-to-back words, no bubble).
  - p_dout is stable while p_valid && !p_ready.
- Backpressure:
  - s_ready = rst_n && (frame_sync || bit_cnt != WIDTH-1 || !p_valid || p_ready).
  - Partial bits keep accumulating while an output word is pending; only the final bit of the next word stalls.
  - s_ready may depend combinationally on p_ready and frame_sync.
- frame_sync=1:
  - bit_cnt and the shift register are treated as 0 this cycle; an accepted bit in the same cycle becomes bit 0 of a new word.
  - The output register is unaffected.
  - frame_sync with no accepted bit leaves bit_cnt=0 next cycle.
- s_valid=0: no state change in the shift path; the output handshake proceeds independently.

Test Plan:
1. WIDTH=8, msb_first=1, p_ready=1, bits 1,1,0,1,0,0,0,0 on consecutive cycles -> p_dout=8'hD0 with p_valid high exactly one cycle, starting the cycle after the 8th bit; bit_cnt returns to 0.
2. Same bit sequence with msb_first=0 -> p_dout=8'h0B. Toggle msb_first after bit 3 of a second msb_first=0 word -> that word is still assembled LSB-first.
3. p_ready=0, stream word A=8'hD0 then 7 bits of word B -> all accepted, bit_cnt=7, s_ready=0 with the 8th bit presented, p_dout holds 8'hD0. Raise p_ready -> 8th bit accepted that cycle, next cycle p_dout = word B, p_valid still 1.
4. Continuous s_valid=1, p_ready=1, 4 words 8'h01,8'h80,8'hFF,8'h5A (MSB-first) -> s_ready never drops; p_valid pulses every 8 cycles with the correct words.
5. After 3 bits, pulse frame_sync with no bit -> bit_cnt=0; next 8 bits 0,1,0,1,1,0,1,0 (MSB-first) -> p_dout=8'h5A, partial bits absent.
6. After 5 bits with a prior word pending (p_ready=0), assert rst_n=0 for one cycle -> p_valid=0, p_dout=0, bit_cnt=0, s_ready=0 during reset. Afterwards 8 bits of 8'hC3 produce p_dout=8'hC3.
